// File: rtl/triumph_if_stage.sv
// Instruction-fetch stage: walks the fetch PC, fetches words from the icache over
// req/gnt/rvalid, buffers {pc, word} in a small FIFO and hands them to decode.
module triumph_if_stage #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        fetch_en_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_gnt_i,
    input  logic        icache_rvalid_i,
    input  logic [31:0] icache_rdata_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_addr_q;

    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q, count_after_pop, count_d;
    logic [31:0]      out_data_q, out_pc_q;
    logic [31:0]      head_data_d, head_pc_d;

    logic             push, pop, can_fetch;
    logic [31:0]      redirect_pc;

    assign redirect_pc = branch_target_i & 32'hFFFF_FFFC;

    // A redirect voids both the incoming word and decode's pop in the same cycle.
    assign push = (state_q == S_WAIT) && icache_rvalid_i && !branch_valid_i;
    assign pop  = (count_q != '0) && id_ready_i && !branch_valid_i;

    assign count_after_pop = pop ? (count_q - CNT_ONE) : count_q;
    assign count_d         = push ? (count_after_pop + CNT_ONE) : count_after_pop;
    assign rd_ptr_d        = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // Every new request is issued with nothing outstanding, so the FIFO level
    // after this cycle's push/pop is the whole occupancy the request must fit in.
    assign can_fetch = fetch_en_i && (count_d < DEPTH_C);

    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (!branch_valid_i && can_fetch) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (icache_gnt_i) begin
                    state_d    = branch_valid_i ? S_FLUSH_WAIT : S_WAIT;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else if (branch_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (icache_rvalid_i) begin
                    state_d = (!branch_valid_i && can_fetch) ? S_REQ : S_IDLE;
                end else if (branch_valid_i) begin
                    state_d = S_FLUSH_WAIT;
                end
            end
            S_FLUSH_WAIT: begin
                // The stale response ends the transaction even if another
                // redirect lands on it; waiting on would never see a second rvalid.
                if (icache_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (branch_valid_i) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // Next value of the registered FIFO head; holds the last word when draining empty.
    always_comb begin
        head_data_d = out_data_q;
        head_pc_d   = out_pc_q;
        if (!branch_valid_i && (count_d != '0)) begin
            if (count_after_pop == '0) begin
                head_data_d = icache_rdata_i;
                head_pc_d   = req_addr_q;
            end else begin
                head_data_d = fifo_data_q[rd_ptr_d];
                head_pc_d   = fifo_pc_q[rd_ptr_d];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= BOOT_ADDR;
            req_addr_q <= BOOT_ADDR;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if ((state_q == S_REQ) && icache_gnt_i) begin
                req_addr_q <= fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            out_pc_q   <= '0;
        end else if (branch_valid_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            count_q    <= count_d;
            out_data_q <= head_data_d;
            out_pc_q   <= head_pc_d;
        end
    end

    // NOTE: buffer storage has no reset; count/pointers guard every read of a stale slot.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= icache_rdata_i;
            fifo_pc_q[wr_ptr_q]   <= req_addr_q;
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_data_o  = out_data_q;
    assign instr_pc_o    = out_pc_q;
    assign icache_req_o  = (state_q == S_REQ);
    assign icache_addr_o = fetch_pc_q;

endmodule

// File: tb/tb_triumph_if_stage.sv
// Directed bench for triumph_if_stage: a small icache responder model plus
// hand-timed redirect, stall, wrap and reset scenarios.
module tb_triumph_if_stage;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic        fetch_en_i;
    logic        branch_valid_i;
    logic [31:0] branch_target_i;
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_data_o;
    logic [31:0] instr_pc_o;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_gnt_i;
    logic        icache_rvalid_i;
    logic [31:0] icache_rdata_i;

    triumph_if_stage #(
        .BOOT_ADDR (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .fetch_en_i     (fetch_en_i),
        .branch_valid_i (branch_valid_i),
        .branch_target_i(branch_target_i),
        .id_ready_i     (id_ready_i),
        .instr_valid_o  (instr_valid_o),
        .instr_data_o   (instr_data_o),
        .instr_pc_o     (instr_pc_o),
        .icache_req_o   (icache_req_o),
        .icache_addr_o  (icache_addr_o),
        .icache_gnt_i   (icache_gnt_i),
        .icache_rvalid_i(icache_rvalid_i),
        .icache_rdata_i (icache_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Icache responder state.
    bit          gnt_allow;
    int          rv_lat;
    bit          pend;
    int          pend_age;
    logic [31:0] pend_addr;

    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    int          req_seen;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + a;
    endfunction

    // Called at the falling edge: sets gnt/rvalid for the next rising edge.
    task automatic drive_cache();
        icache_rvalid_i = 1'b0;
        if (pend) begin
            pend_age++;
            if (pend_age >= rv_lat) begin
                icache_rvalid_i = 1'b1;
                icache_rdata_i  = mem_word(pend_addr);
                pend            = 1'b0;
            end
        end
        icache_gnt_i = icache_req_o && gnt_allow;
        if (icache_gnt_i) begin
            pend      = 1'b1;
            pend_age  = 0;
            pend_addr = icache_addr_o;
        end
    endtask

    // One clock: log the handshake about to complete, then advance to the next falling edge.
    task automatic step();
        if (rstn_i && instr_valid_o && id_ready_i && !branch_valid_i) begin
            got_pc.push_back(instr_pc_o);
            got_data.push_back(instr_data_o);
        end
        @(negedge clk_i);
        branch_valid_i = 1'b0;
        drive_cache();
        if (icache_req_o) req_seen++;
    endtask

    task automatic check_stream(input string tag, input logic [31:0] first_pc, input int n);
        logic [31:0] pc;
        check({tag, "_enough"}, 32'(got_pc.size() >= n), 32'd1);
        for (int i = 0; i < n && i < got_pc.size(); i++) begin
            pc = first_pc + 32'(4 * i);
            check({tag, "_pc"}, got_pc[i], pc);
            check({tag, "_data"}, got_data[i], mem_word(pc));
        end
    endtask

    task automatic do_reset(input string tag);
        rstn_i          = 1'b0;
        fetch_en_i      = 1'b0;
        branch_valid_i  = 1'b0;
        branch_target_i = '0;
        id_ready_i      = 1'b0;
        icache_gnt_i    = 1'b0;
        icache_rvalid_i = 1'b0;
        icache_rdata_i  = '0;
        pend            = 1'b0;
        gnt_allow       = 1'b1;
        rv_lat          = 1;
        req_seen        = 0;
        got_pc.delete();
        got_data.delete();
        repeat (2) @(negedge clk_i);
        check({tag, "_rst_valid"}, 32'(instr_valid_o), 32'd0);
        check({tag, "_rst_data"}, instr_data_o, 32'h0);
        check({tag, "_rst_pc"}, instr_pc_o, 32'h0);
        check({tag, "_rst_req"}, 32'(icache_req_o), 32'd0);
        check({tag, "_rst_addr"}, icache_addr_o, 32'h0);
        rstn_i = 1'b1;
    endtask

    initial begin
        // T1: basic fetch, first-word latency and steady-state throughput.
        do_reset("t1");
        fetch_en_i = 1'b1;
        id_ready_i = 1'b1;
        step();
        check("t1_req_first", 32'(icache_req_o), 32'd1);
        check("t1_addr_first", icache_addr_o, 32'h0);
        check("t1_valid_early", 32'(instr_valid_o), 32'd0);
        step();
        check("t1_req_wait", 32'(icache_req_o), 32'd0);
        check("t1_addr_next", icache_addr_o, 32'h4);
        check("t1_valid_wait", 32'(instr_valid_o), 32'd0);
        step();
        check("t1_valid", 32'(instr_valid_o), 32'd1);
        check("t1_pc", instr_pc_o, 32'h0);
        check("t1_data", instr_data_o, 32'h0050_0093);
        check("t1_req_again", 32'(icache_req_o), 32'd1);
        check("t1_addr_again", icache_addr_o, 32'h4);
        repeat (20) step();
        check("t1_throughput", 32'(got_pc.size()), 32'd10);
        check_stream("t1_stream", 32'h0, 10);

        // T2: decode stalled, buffer fills to depth and fetching stops.
        do_reset("t2");
        fetch_en_i = 1'b1;
        repeat (5) step();
        req_seen = 0;
        repeat (5) step();
        check("t2_req_quiet", 32'(req_seen), 32'd0);
        check("t2_valid_full", 32'(instr_valid_o), 32'd1);
        check("t2_head_pc", instr_pc_o, 32'h0);
        check("t2_fetch_pc", icache_addr_o, 32'h8);
        fetch_en_i = 1'b0;
        id_ready_i = 1'b1;
        repeat (6) step();
        check("t2_drained", 32'(got_pc.size()), 32'd2);
        check_stream("t2_stream", 32'h0, 2);
        check("t2_empty", 32'(instr_valid_o), 32'd0);
        check("t2_hold_pc", instr_pc_o, 32'h4);

        // T3: redirect while waiting on a late response.
        do_reset("t3");
        fetch_en_i = 1'b1;
        id_ready_i = 1'b1;
        rv_lat     = 3;
        step();
        step();
        branch_valid_i  = 1'b1;
        branch_target_i = 32'h0000_0100;
        step();
        check("t3_addr_redir", icache_addr_o, 32'h100);
        check("t3_req_flush", 32'(icache_req_o), 32'd0);
        check("t3_valid_flush", 32'(instr_valid_o), 32'd0);
        step();
        check("t3_late_rvalid", 32'(icache_rvalid_i), 32'd1);
        rv_lat = 1;
        repeat (10) step();
        check_stream("t3_stream", 32'h100, 2);

        // T4: redirect coinciding with the grant, unaligned target.
        do_reset("t4");
        fetch_en_i = 1'b1;
        id_ready_i = 1'b1;
        step();
        check("t4_gnt", 32'(icache_gnt_i), 32'd1);
        branch_valid_i  = 1'b1;
        branch_target_i = 32'h0000_0203;
        step();
        check("t4_addr_redir", icache_addr_o, 32'h200);
        check("t4_req_flush", 32'(icache_req_o), 32'd0);
        check("t4_valid_a", 32'(instr_valid_o), 32'd0);
        step();
        check("t4_valid_b", 32'(instr_valid_o), 32'd0);
        check("t4_req_idle", 32'(icache_req_o), 32'd0);
        step();
        check("t4_req_refetch", 32'(icache_req_o), 32'd1);
        check("t4_addr_refetch", icache_addr_o, 32'h200);
        repeat (8) step();
        check_stream("t4_stream", 32'h200, 2);

        // T5: grant withheld, then address wrap at the top of memory.
        do_reset("t5");
        fetch_en_i      = 1'b1;
        id_ready_i      = 1'b1;
        gnt_allow       = 1'b0;
        branch_valid_i  = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        step();
        check("t5_idle_on_redir", 32'(icache_req_o), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t5_req_held", 32'(icache_req_o), 32'd1);
            check("t5_addr_held", icache_addr_o, 32'hFFFF_FFFC);
            if (i == 4) gnt_allow = 1'b1;
            step();
        end
        step();
        check("t5_addr_wrap", icache_addr_o, 32'h0);
        repeat (8) step();
        check_stream("t5_stream", 32'hFFFF_FFFC, 2);

        // T6: asynchronous reset in the middle of a transaction.
        do_reset("t6");
        fetch_en_i = 1'b1;
        repeat (4) step();
        check("t6_pre_valid", 32'(instr_valid_o), 32'd1);
        check("t6_pre_addr", icache_addr_o, 32'h8);
        #2;
        rstn_i = 1'b0;
        pend   = 1'b0;
        #1;
        check("t6_async_valid", 32'(instr_valid_o), 32'd0);
        check("t6_async_data", instr_data_o, 32'h0);
        check("t6_async_pc", instr_pc_o, 32'h0);
        check("t6_async_req", 32'(icache_req_o), 32'd0);
        check("t6_async_addr", icache_addr_o, 32'h0);
        do_reset("t6b");
        fetch_en_i = 1'b1;
        id_ready_i = 1'b1;
        step();
        check("t6_restart_req", 32'(icache_req_o), 32'd1);
        check("t6_restart_addr", icache_addr_o, 32'h0);
        repeat (6) step();
        check_stream("t6_stream", 32'h0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
